// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RV32I/RV64I immediate decode with PC-relative target, buffered in a DEPTH-entry FIFO
module imm_gen_stage #(
  parameter int XLEN = 64,
  parameter int DEPTH = 2,
  parameter bit EN_CSR = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] imme_o,
  output logic [XLEN-1:0] target_o,
  output logic [2:0]      imm_kind_o,
  output logic            illegal_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);
  localparam bit RV64 = XLEN == 64;
  localparam logic [2:0] K_NONE = 3'd0, K_I = 3'd1, K_S = 3'd2, K_B = 3'd3,
                         K_U = 3'd4, K_J = 3'd5, K_Z = 3'd6;
  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [2:0]      kind;
    logic            ill;
  } ent_t;
  logic [6:0] opc;
  logic [2:0] f3;
  logic sh, ill, tgt_en;
  logic [2:0] kind;
  logic [63:0] imm64, imm_i, imm_s, imm_b, imm_j, imm_u;
  ent_t dec, head;
  ent_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic push, pop;
  assign opc = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign sh = f3[1:0] == 2'b01;
  // Immediates are built at 64 bits and truncated, so XLEN=32 needs no separate extension logic
  assign imm_i = {{52{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{52{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{44{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
  always_comb begin
    kind = K_NONE;
    imm64 = '0;
    ill = 1'b0;
    case (opc)
      7'h13: begin
        kind = K_I;
        imm64 = sh ? (RV64 ? {58'b0, inst_i[25:20]} : {59'b0, inst_i[24:20]}) : imm_i;
        ill = sh & ~RV64 & inst_i[25];
      end
      7'h03, 7'h67: begin
        kind = K_I;
        imm64 = imm_i;
      end
      7'h1b: begin
        kind = K_I;
        imm64 = sh ? {59'b0, inst_i[24:20]} : imm_i;
        ill = ~RV64;
      end
      7'h23: begin
        kind = K_S;
        imm64 = imm_s;
      end
      7'h63: begin
        kind = K_B;
        imm64 = imm_b;
      end
      7'h6f: begin
        kind = K_J;
        imm64 = imm_j;
      end
      7'h37, 7'h17: begin
        kind = K_U;
        imm64 = imm_u;
      end
      7'h73: begin
        kind = EN_CSR ? (f3[2] ? K_Z : K_I) : K_NONE;
        imm64 = EN_CSR ? (f3[2] ? {59'b0, inst_i[19:15]} : {52'b0, inst_i[31:20]}) : '0;
      end
      7'h33, 7'h0f: ill = 1'b0;
      7'h3b: ill = ~RV64;
      default: ill = 1'b1;
    endcase
  end
  assign tgt_en = kind == K_B || kind == K_J || opc == 7'h17;
  assign dec.inst = inst_i;
  assign dec.ill = ill;
  assign dec.kind = ill ? K_NONE : kind;
  assign dec.imm = ill ? '0 : imm64[XLEN-1:0];
  assign dec.tgt = (ill | ~tgt_en) ? '0 : pc_i + imm64[XLEN-1:0];
  assign in_ready_o = count < FULL;
  assign out_valid_o = count != 3'd0;
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop = out_valid_o & out_ready_i;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + 3'(push) - 3'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dec;
  end
  assign head = mem[rd_ptr];
  assign inst_o = out_valid_o ? head.inst : '0;
  assign imme_o = out_valid_o ? head.imm : '0;
  assign target_o = out_valid_o ? head.tgt : '0;
  assign imm_kind_o = out_valid_o ? head.kind : K_NONE;
  assign illegal_o = out_valid_o & head.ill;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: random and directed checks of 64- and 32-bit instances against a reference model
module tb_imm_gen_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;
  logic r64, v64, il64, r32, v32, il32;
  logic [31:0] i64, i32;
  logic [63:0] m64, t64;
  logic [31:0] m32, t32;
  logic [2:0] k64, k32;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  kind;
    logic        ill;
  } ent_t;
  ent_t q64[$], q32[$];
  imm_gen_stage #(.XLEN(64), .DEPTH(2)) u64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r64),
    .inst_i(inst), .pc_i(pc), .out_valid_o(v64), .out_ready_i(out_ready), .inst_o(i64),
    .imme_o(m64), .target_o(t64), .imm_kind_o(k64), .illegal_o(il64));
  imm_gen_stage #(.XLEN(32), .DEPTH(2)) u32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(r32),
    .inst_i(inst), .pc_i(pc[31:0]), .out_valid_o(v32), .out_ready_i(out_ready), .inst_o(i32),
    .imme_o(m32), .target_o(t32), .imm_kind_o(k32), .illegal_o(il32));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // value of an n-bit two's-complement field
  function automatic longint sx(input longint v, input int n);
    return v >= (64'sd1 <<< (n - 1)) ? v - (64'sd1 <<< n) : v;
  endfunction
  function automatic ent_t ref_dec(input logic [31:0] i, input logic [63:0] p, input bit x64);
    ent_t e;
    longint v = 0;
    int kind = 0;
    bit ill = 0;
    bit shift = i[14:12] == 3'd1 || i[14:12] == 3'd5;
    logic [63:0] mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (i[6:0])
      7'h13: begin
        kind = 1;
        v = shift ? (x64 ? longint'(i[25:20]) : longint'(i[24:20])) : sx(longint'(i[31:20]), 12);
        ill = shift && !x64 && i[25];
      end
      7'h03, 7'h67: begin kind = 1; v = sx(longint'(i[31:20]), 12); end
      7'h1b: begin
        kind = 1;
        v = shift ? longint'(i[24:20]) : sx(longint'(i[31:20]), 12);
        ill = !x64;
      end
      7'h23: begin kind = 2; v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12); end
      7'h63: begin
        kind = 3;
        v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      end
      7'h6f: begin
        kind = 5;
        v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      end
      7'h37, 7'h17: begin kind = 4; v = sx(longint'(i[31:12]) * 4096, 32); end
      7'h73: begin kind = i[14] ? 6 : 1; v = i[14] ? longint'(i[19:15]) : longint'(i[31:20]); end
      7'h33, 7'h0f: ill = 0;
      7'h3b: ill = !x64;
      default: ill = 1;
    endcase
    if (ill) begin kind = 0; v = 0; end
    e.inst = i;
    e.ill = ill;
    e.kind = 3'(kind);
    e.imm = 64'(v) & mask;
    e.tgt = (kind == 3 || kind == 5 || i[6:0] == 7'h17) ? (p + 64'(v)) & mask : 64'd0;
    return e;
  endfunction
  task automatic check_outs();
    chk("rdy64", r64, q64.size() < 2);
    chk("rdy32", r32, q32.size() < 2);
    chk("vld64", v64, q64.size() > 0);
    chk("vld32", v32, q32.size() > 0);
    if (q64.size() > 0) begin
      chk("inst64", i64, q64[0].inst);
      chk("imm64", m64, q64[0].imm);
      chk("tgt64", t64, q64[0].tgt);
      chk("kind64", k64, q64[0].kind);
      chk("ill64", il64, q64[0].ill);
    end
    if (q32.size() > 0) begin
      chk("inst32", i32, q32[0].inst);
      chk("imm32", m32, q32[0].imm);
      chk("tgt32", t32, q32[0].tgt);
      chk("kind32", k32, q32[0].kind);
      chk("ill32", il32, q32[0].ill);
    end
  endtask
  // called at a negedge: drive, check current head, advance one cycle, update the model
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] p, input bit rdy, input bit fl);
    bit acc, pp;
    ent_t e64, e32;
    in_valid = v;
    inst = ins;
    pc = p;
    out_ready = rdy;
    flush = fl;
    #1;
    check_outs();
    acc = v && q64.size() < 2 && !fl;
    pp = rdy && q64.size() > 0;
    e64 = ref_dec(ins, p, 1);
    e32 = ref_dec(ins, p & 64'hFFFF_FFFF, 0);
    @(posedge clk);
    if (pp) begin void'(q64.pop_front()); void'(q32.pop_front()); end
    if (fl) begin q64.delete(); q32.delete(); end
    else if (acc) begin q64.push_back(e64); q32.push_back(e32); end
    @(negedge clk);
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [14] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63, 7'h6f,
                             7'h37, 7'h17, 7'h73, 7'h33, 7'h3b, 7'h0f, 7'h13};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 13)];
    return w;
  endfunction
  initial begin
    #1;
    chk("rst_vld64", v64, 0);
    chk("rst_imm64", m64, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0);
    // branch, lui, csrrwi, slli
    step(1, 32'hFE000EE3, 64'h80000010, 1, 0);
    chk("br_kind", k64, 3);
    chk("br_imm", m64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("br_tgt", t64, 64'h0000_0000_8000_000C);
    step(1, 32'h80000537, 64'h1000, 1, 0);
    chk("lui_imm", m64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_kind", k64, 4);
    step(1, 32'h3400D073, 64'h1004, 1, 0);
    chk("csr_imm", m64, 1);
    chk("csr_kind", k64, 6);
    step(1, 32'h03F09093, 64'h1008, 1, 0);
    chk("sll_imm", m64, 63);
    chk("sll_kind", k64, 1);
    chk("sll32_ill", il32, 1);
    chk("sll32_kind", k32, 0);
    chk("sll32_imm", m32, 0);
    step(1, 32'h0010009B, 64'h100C, 1, 0);
    chk("w32_ill", il32, 1);
    chk("w32_imm", m32, 0);
    step(1, 32'h00000000, 64'h1010, 1, 0);
    chk("zero_ill", il64, 1);
    chk("zero32_ill", il32, 1);
    step(0, 0, 0, 1, 0);
    // backpressure: three offered with consumer stalled
    step(1, 32'h00100093, 64'h2000, 0, 0);
    step(1, 32'h00200113, 64'h2004, 0, 0);
    step(1, 32'h00300193, 64'h2008, 0, 0);
    chk("bp_full", r64, 0);
    chk("bp_head", i64, 32'h00100093);
    for (int k = 0; k < 4; k++) step(k < 2, 32'h00300193, 64'h2008, 1, 0);
    // flush with a simultaneous push
    step(1, 32'h00400213, 64'h3000, 0, 0);
    step(1, 32'h00500293, 64'h3004, 0, 0);
    step(1, 32'h00600313, 64'h3008, 0, 1);
    chk("fl_vld", v64, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, rnd_inst(), {$urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0);
    // asynchronous reset with two entries held
    step(1, 32'h00700393, 64'h4000, 0, 0);
    step(1, 32'h00800413, 64'h4004, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld64", v64, 0);
    chk("arst_imm64", m64, 0);
    chk("arst_vld32", v32, 0);
    q64.delete();
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0);
    chk("arst_rdy", r64, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between fetch and decode/execute.
- Decodes the immediate for every RV32I/RV64I base format plus Zicsr zimm and RV64 shift amounts.
- Computes the PC-relative target for branch, jal and auipc, and flags illegal encodings.
- Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus a flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- DEPTH, 2, output FIFO entries; legal range 1..4.
- EN_CSR, 1, when 0 the SYSTEM opcode (0x73) produces kind NONE and imm 0.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- flush_i  input  1  synchronous flush; empties the FIFO.
- in_valid_i  input  1  inst_i/pc_i valid.
- in_ready_o  output  1  stage can accept this cycle.
- inst_i  input  32  instruction word.
- pc_i  input  XLEN  instruction address.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  consumer takes head entry.
- inst_o  output  32  instruction of head entry.
- imme_o  output  XLEN  immediate of head entry.
- target_o  output  XLEN  pc+imm for kinds B, J and auipc; 0 otherwise.
- imm_kind_o  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- illegal_o  output  1  head entry is an illegal encoding.

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - FIFO count and pointers cleared.
  - out_valid_o=0, all other outputs 0.
  - in_ready_o=1 from the first cycle after release.
- Decode is combinational from inst_i/pc_i. The result is written into the FIFO on accept (in_valid_i & in_ready_o).
- Handshakes:
  - in_ready_o = (count < DEPTH). There is no same-cycle pass-through when full.
  - Pop occurs on out_valid_o & out_ready_i.
  - Outputs always reflect the head entry and are held stable while out_valid_o=1 and out_ready_i=0.
- Latency: an instruction accepted in cycle N into an empty FIFO appears at the outputs in cycle N+1.
- Push and pop in the same cycle: count unchanged, order preserved. This is legal at count=DEPTH only for the pop; the push is refused because in_ready_o=0.
- Flush:
  - flush_i=1 clears count and pointers at the next edge; out_valid_o=0 in the next cycle.
  - An input presented in the flush cycle is dropped.
  - A pop in the flush cycle still completes for the consumer.
  - Flush has priority over push.
- Immediate rules (sext = sign-extend to XLEN, zext = zero-extend to XLEN):
  - 0x13 / 0x03 / 0x67: I, sext(inst[31:20]).
  - 0x13 shifts (funct3 001 or 101): I, zext(inst[25:20]) for XLEN=64, zext(inst[24:20]) for XLEN=32.
  - 0x1b: I, sext(inst[31:20]); shifts in 0x1b use zext(inst[24:20]).
  - 0x23: S, sext({inst[31:25],inst[11:7]}).
  - 0x63: B, sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - 0x6f: J, sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - 0x37 / 0x17: U, sext({inst[31:12],12'b0}), sign taken from bit 31.
  - 0x73 with funct3[2]=1: Z, zext(inst[19:15]).
  - 0x73 with funct3[2]=0: I, zext(inst[31:20]).
  - 0x33 / 0x3b / 0x0f: NONE, imm 0.
- target_o = pc_i + imm modulo 2^XLEN for B, J and auipc; jalr gives target 0.
- illegal_o=1, kind NONE, imm 0, target 0 when any of the following holds:
  - inst[1:0] != 2'b11;
  - the opcode is outside the set above;
  - XLEN=32 and the opcode is 0x1b or 0x3b;
  - XLEN=32 and an 0x13 shift has inst[25]=1.
- Illegal instructions still flow through the FIFO in order.

Test Plan:
- Reset: assert rst_n_i low mid-operation with the FIFO holding 2 entries -> out_valid_o=0 and imme_o=0 immediately; in_ready_o=1 after release.
- Branch: XLEN=64, inst 0xFE000EE3, pc 0x80000010, out_ready_i=1 -> next cycle kind=3, imme_o=0xFFFFFFFFFFFFFFFC, target_o=0x000000008000000C.
- U/Z/shift kinds:
  - lui 0x80000537 -> imme_o=0xFFFFFFFF80000000, kind 4.
  - csrrwi 0x3400D073 -> imme_o=1, kind 6.
  - slli 0x03F09093 -> imme_o=63, kind 1.
- XLEN=32: inst 0x03F09093 -> illegal_o=1, kind 0, imme_o=0. Same check for opcode 0x1b and for inst 0x00000000.
- Backpressure: DEPTH=2, out_ready_i=0, offer 3 instructions -> 2 accepted, then in_ready_o=0 and the third is held. Release out_ready_i -> all three emerge in order, one per cycle.
- Flush: FIFO holds 2 entries; assert flush_i with a simultaneous valid push -> next cycle out_valid_o=0, and the pushed instruction never appears.
